// File: rtl/snn_readout_pkg.sv
// Shared types, default widths and the saturating adder for the SNN spike-count readout path.
package snn_readout_pkg;

  localparam int DEFAULT_NUM_OUTPUTS = 10;
  localparam int DEFAULT_ADDR_BITS   = 4;
  localparam int DEFAULT_COUNT_WIDTH = 32;

  // Working width of sat_add; count widths up to SAT_W bits are supported.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESULT
  } argmax_state_t;

  // Adds two zero-extended operands and clamps the result to 2**width-1.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input int               width
  );
    logic [SAT_W:0] sum;
    logic [SAT_W:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    if (sum > limit) begin
      return limit[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running max / runner-up / tie / saturating-sum accumulator, updated by one tagged count word per cycle.
// Outputs are the next-state values so the caller can capture the final word in the same cycle it lands.
module argmax_tracker
  import snn_readout_pkg::*;
#(
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [ADDR_BITS-1:0]   idx_i,
  input  logic [COUNT_WIDTH-1:0] data_i,
  output logic [COUNT_WIDTH-1:0] max_d_o,
  output logic [COUNT_WIDTH-1:0] runner_d_o,
  output logic [COUNT_WIDTH-1:0] sum_d_o,
  output logic [ADDR_BITS-1:0]   idx_d_o,
  output logic                   tie_d_o
);

  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic [COUNT_WIDTH-1:0] runner_q, runner_d;
  logic [COUNT_WIDTH-1:0] sum_q, sum_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic                   tie_q, tie_d;

  // Strict greater-than keeps the lowest index as winner; index 0 never raises tie against the cleared max.
  always_comb begin
    max_d    = max_q;
    runner_d = runner_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    tie_d    = tie_q;
    if (clear_i) begin
      max_d    = '0;
      runner_d = '0;
      sum_d    = '0;
      idx_d    = '0;
      tie_d    = 1'b0;
    end else if (valid_i) begin
      if (data_i > max_q) begin
        runner_d = max_q;
        max_d    = data_i;
        idx_d    = idx_i;
        tie_d    = 1'b0;
      end else if ((data_i == max_q) && (idx_i != '0)) begin
        tie_d    = 1'b1;
        runner_d = data_i;
      end else if (data_i > runner_q) begin
        runner_d = data_i;
      end
      sum_d = COUNT_WIDTH'(sat_add(SAT_W'(sum_q), SAT_W'(data_i), COUNT_WIDTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_q    <= '0;
      runner_q <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      tie_q    <= 1'b0;
    end else begin
      max_q    <= max_d;
      runner_q <= runner_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      tie_q    <= tie_d;
    end
  end

  assign max_d_o    = max_d;
  assign runner_d_o = runner_d;
  assign sum_d_o    = sum_d;
  assign idx_d_o    = idx_d;
  assign tie_d_o    = tie_d;

endmodule

// File: rtl/spike_count_argmax.sv
// Sequential scan of the output-spike-count RAM producing winner/runner-up/total/tie/no-spike results on valid/ready.
// Optional margin_thresh_i / confident_o ports are enabled with `define SPIKE_ARGMAX_MARGIN_EN.
module spike_count_argmax
  import snn_readout_pkg::*;
#(
  parameter int NUM_OUTPUTS            = DEFAULT_NUM_OUTPUTS,
  parameter int OUTPUT_SPIKE_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int COUNT_WIDTH            = DEFAULT_COUNT_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  output logic                              mem_rd_en_o,
  output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] mem_addr_o,
  input  logic [COUNT_WIDTH-1:0]            mem_rdata_i,
  output logic                              busy_o,
  output logic                              result_valid_o,
  input  logic                              result_ready_i,
  output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] winner_idx_o,
  output logic [COUNT_WIDTH-1:0]            winner_count_o,
  output logic [COUNT_WIDTH-1:0]            runner_up_count_o,
  output logic [COUNT_WIDTH-1:0]            total_spikes_o,
  output logic                              tie_o,
  output logic                              no_spikes_o
`ifdef SPIKE_ARGMAX_MARGIN_EN
  ,
  input  logic [COUNT_WIDTH-1:0]            margin_thresh_i,
  output logic                              confident_o
`endif
);

  localparam int A = OUTPUT_SPIKE_ADDR_BITS;
  localparam logic [A-1:0] LAST_ADDR = A'(NUM_OUTPUTS - 1);

  argmax_state_t state_q, state_d;
  logic [A-1:0]  rd_ptr_q, rd_ptr_d;
  logic          tag_valid_q;
  logic [A-1:0]  tag_idx_q;
  logic          scan_start;
  logic          scan_done;

  logic [COUNT_WIDTH-1:0] trk_max, trk_runner, trk_sum;
  logic [A-1:0]           trk_idx;
  logic                   trk_tie;
  logic                   final_tie;

  logic [A-1:0]           winner_idx_q;
  logic [COUNT_WIDTH-1:0] winner_count_q;
  logic [COUNT_WIDTH-1:0] runner_up_q;
  logic [COUNT_WIDTH-1:0] total_q;
  logic                   tie_q;
  logic                   no_spikes_q;

  assign scan_start = (state_q == IDLE) && start_i;
  assign scan_done  = (state_q == DRAIN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = READ;
      READ:    if (rd_ptr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN:   state_d = RESULT;
      RESULT:  if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en_o    = 1'b0;
    mem_addr_o     = '0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      READ: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = rd_ptr_q;
        busy_o      = 1'b1;
      end
      DRAIN:   busy_o = 1'b1;
      RESULT:  result_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (scan_start) begin
      rd_ptr_d = '0;
    end else if (state_q == READ) begin
      rd_ptr_d = rd_ptr_q + A'(1);
    end
  end

  // RAM data returns one cycle after the strobe, so the strobe and address are delayed to tag it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      tag_valid_q <= mem_rd_en_o;
      tag_idx_q   <= mem_addr_o;
    end
  end

  argmax_tracker #(
    .ADDR_BITS  (A),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (scan_start),
    .valid_i   (tag_valid_q),
    .idx_i     (tag_idx_q),
    .data_i    (mem_rdata_i),
    .max_d_o   (trk_max),
    .runner_d_o(trk_runner),
    .sum_d_o   (trk_sum),
    .idx_d_o   (trk_idx),
    .tie_d_o   (trk_tie)
  );

  // An all-zero scan matches equal counts everywhere but is reported as no_spikes rather than a tie.
  assign final_tie = trk_tie && (trk_max != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || scan_start) begin
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      runner_up_q    <= '0;
      total_q        <= '0;
      tie_q          <= 1'b0;
      no_spikes_q    <= 1'b0;
    end else if (scan_done) begin
      winner_idx_q   <= trk_idx;
      winner_count_q <= trk_max;
      runner_up_q    <= trk_runner;
      total_q        <= trk_sum;
      tie_q          <= final_tie;
      no_spikes_q    <= (trk_max == '0);
    end
  end

  assign winner_idx_o      = winner_idx_q;
  assign winner_count_o    = winner_count_q;
  assign runner_up_count_o = runner_up_q;
  assign total_spikes_o    = total_q;
  assign tie_o             = tie_q;
  assign no_spikes_o       = no_spikes_q;

`ifdef SPIKE_ARGMAX_MARGIN_EN
  logic confident_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || scan_start) begin
      confident_q <= 1'b0;
    end else if (scan_done) begin
      confident_q <= !final_tie && (trk_max != '0) &&
                     ((trk_max - trk_runner) >= margin_thresh_i);
    end
  end

  assign confident_o = confident_q;
`endif

endmodule

// File: tb/tb_spike_count_argmax.sv
// Self-checking bench for spike_count_argmax: directed scans plus randomized count patterns against a reference model.
module tb_spike_count_argmax;

  localparam int N = 4;
  localparam int A = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         memRdEn;
  logic [A-1:0] memAddr;
  logic [W-1:0] memRdata = '0;
  logic         busy;
  logic         resultValid;
  logic         resultReady;
  logic [A-1:0] winnerIdx;
  logic [W-1:0] winnerCount;
  logic [W-1:0] runnerUpCount;
  logic [W-1:0] totalSpikes;
  logic         tie;
  logic         noSpikes;

  logic [W-1:0] ram [16];

  int testCount = 0;
  int failCount = 0;

  logic [A-1:0] expIdx;
  logic [W-1:0] expMax;
  logic [W-1:0] expRunner;
  logic [W-1:0] expSum;
  logic         expTie;
  logic         expNone;

  spike_count_argmax #(
    .NUM_OUTPUTS           (N),
    .OUTPUT_SPIKE_ADDR_BITS(A),
    .COUNT_WIDTH           (W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .mem_rd_en_o      (memRdEn),
    .mem_addr_o       (memAddr),
    .mem_rdata_i      (memRdata),
    .busy_o           (busy),
    .result_valid_o   (resultValid),
    .result_ready_i   (resultReady),
    .winner_idx_o     (winnerIdx),
    .winner_count_o   (winnerCount),
    .runner_up_count_o(runnerUpCount),
    .total_spikes_o   (totalSpikes),
    .tie_o            (tie),
    .no_spikes_o      (noSpikes)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (memRdEn) memRdata <= ram[memAddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: winner is the first index holding the maximum, runner-up is the second entry of the
  // descending-sorted counts, total is the exact sum clamped to the count range.
  task automatic computeExpected(input logic [W-1:0] c [N]);
    logic [W-1:0] sorted [$];
    longint unsigned s;
    int occ;
    s = 0;
    occ = 0;
    expMax = '0;
    for (int i = 0; i < N; i++) if (c[i] > expMax) expMax = c[i];
    for (int i = N - 1; i >= 0; i--) if (c[i] == expMax) expIdx = A'(i);
    for (int i = 0; i < N; i++) if (c[i] == expMax) occ++;
    for (int i = 0; i < N; i++) sorted.push_back(c[i]);
    sorted.rsort();
    expRunner = sorted[1];
    for (int i = 0; i < N; i++) begin
      s = s + longint'(c[i]);
      if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
    end
    expSum  = W'(s);
    expNone = (expMax == '0);
    expTie  = (occ > 1) && !expNone;
  endtask

  task automatic checkIdleZero();
    checkOutput("zero_rd_en", 64'(memRdEn), 64'd0);
    checkOutput("zero_addr", 64'(memAddr), 64'd0);
    checkOutput("zero_busy", 64'(busy), 64'd0);
    checkOutput("zero_valid", 64'(resultValid), 64'd0);
    checkOutput("zero_results", {winnerCount, runnerUpCount}, 64'd0);
    checkOutput("zero_total", 64'(totalSpikes), 64'd0);
    checkOutput("zero_idx_flags", {58'd0, winnerIdx, tie, noSpikes}, 64'd0);
  endtask

  task automatic applyStimulus(input logic [W-1:0] c [N], input int holdCycles, input bit pokeStart);
    int cycles;
    int rdCount;
    bit stable;
    for (int i = 0; i < N; i++) ram[i] = c[i];
    computeExpected(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    rdCount = memRdEn ? 1 : 0;
    while (!resultValid && cycles < 40) begin
      tick();
      cycles++;
      if (memRdEn) rdCount++;
    end
    checkOutput("latency", 64'(cycles), 64'(N + 2));
    checkOutput("rd_count", 64'(rdCount), 64'(N));
    checkOutput("winner_idx", 64'(winnerIdx), 64'(expIdx));
    checkOutput("winner_count", 64'(winnerCount), 64'(expMax));
    checkOutput("runner_up", 64'(runnerUpCount), 64'(expRunner));
    checkOutput("total", 64'(totalSpikes), 64'(expSum));
    checkOutput("tie", 64'(tie), 64'(expTie));
    checkOutput("no_spikes", 64'(noSpikes), 64'(expNone));
    stable = 1'b1;
    for (int k = 0; k < holdCycles; k++) begin
      start = pokeStart && (k % 3 == 0);
      tick();
      start = 1'b0;
      if (!(resultValid === 1'b1 && winnerIdx === expIdx && winnerCount === expMax &&
            runnerUpCount === expRunner && totalSpikes === expSum && tie === expTie &&
            noSpikes === expNone && busy === 1'b0)) stable = 1'b0;
    end
    if (holdCycles > 0) checkOutput("hold_stable", 64'(stable), 64'd1);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    checkOutput("valid_drop", 64'(resultValid), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("start_not_queued", {62'd0, busy, resultValid}, 64'd0);
    checkOutput("result_held", {winnerCount, totalSpikes}, {expMax, expSum});
  endtask

  initial begin
    logic [W-1:0] pat [N];
    int waits;
    bit quiet;
    int mode;

    rst = 1'b1;
    start = 1'b0;
    resultReady = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    tick();
    tick();
    checkIdleZero();
    rst = 1'b0;
    tick();

    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    checkOutput("ready_ignored", {62'd0, busy, resultValid}, 64'd0);

    pat = '{32'd3, 32'd9, 32'd2, 32'd7};
    applyStimulus(pat, 0, 1'b0);
    pat = '{32'd5, 32'd1, 32'd5, 32'd0};
    applyStimulus(pat, 2, 1'b0);
    pat = '{32'd0, 32'd0, 32'd0, 32'd0};
    applyStimulus(pat, 1, 1'b0);
    pat = '{32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0};
    applyStimulus(pat, 0, 1'b0);
    pat = '{32'd4, 32'd4, 32'd8, 32'd1};
    applyStimulus(pat, 20, 1'b1);
    pat = '{32'd0, 32'd0, 32'd3, 32'd3};
    applyStimulus(pat, 0, 1'b0);

    // Reset arriving mid-scan at address 2.
    pat = '{32'd6, 32'd2, 32'd9, 32'd3};
    for (int i = 0; i < N; i++) ram[i] = pat[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    waits = 0;
    while (!(memRdEn === 1'b1 && memAddr === A'(2)) && waits < 10) begin
      tick();
      waits++;
    end
    checkOutput("reached_addr2", 64'(waits < 10), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleZero();
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (resultValid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checkOutput("no_valid_after_rst", 64'(quiet), 64'd1);
    applyStimulus(pat, 1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       pat[i] = W'($urandom_range(0, 3));
          1:       pat[i] = $urandom;
          default: pat[i] = 32'hFFFF_0000 + W'($urandom_range(0, 16'hFFFF));
        endcase
      end
      applyStimulus(pat, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
